// File: rtl/fmps_stream_packetizer.sv
// FMPS record stream packetizer: frames records into header/records/trailer
// packets on an AXI4-Stream port. Optional macro: FMPS_STREAM_TIMESTAMP_EN.
module fmps_stream_packetizer #(
    parameter int INDEX_WIDTH = 5,
    parameter int FIFO_AW     = 6
) (
    input  logic                      sysClk,
    input  logic                      sysReset_n,
    input  logic                      FAstrobe,
    input  logic [2**INDEX_WIDTH-1:0] fmpsBitmapAll,
    input  logic [INDEX_WIDTH-1:0]    fmpsIndex,
    input  logic [31:0]               fmpsData,
    input  logic                      fmpsValid,
    output logic [31:0]               M_TDATA,
    output logic [INDEX_WIDTH-1:0]    M_TUSER,
    output logic                      M_TVALID,
    output logic                      M_TLAST,
    input  logic                      M_TREADY,
    output logic [15:0]               dropCount,
    output logic                      overflow
);

    localparam int NBITS = 2**INDEX_WIDTH;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = INDEX_WIDTH + 1;
    localparam int EW    = 33 + INDEX_WIDTH;
`ifdef FMPS_STREAM_TIMESTAMP_EN
    localparam int RESERVE = 3;
    typedef enum logic [1:0] {IDLE, COLLECT, OPEN, STAMP} state_t;
`else
    localparam int RESERVE = 2;
    typedef enum logic [1:0] {IDLE, COLLECT, OPEN} state_t;
`endif

    state_t state, stateNext;

    logic [7:0]          seq;
    logic [CW-1:0]       expected;
    logic [CW-1:0]       received;
    logic [CW-1:0]       popCount;
    logic [EW-1:0]       mem [DEPTH];
    logic [EW-1:0]       headWord;
    logic [EW-1:0]       wrWord;
    logic [FIFO_AW-1:0]  wrPtr, rdPtr;
    logic [FIFO_AW:0]    count, free;
    logic                wrEn, rdEn;
    logic                latchFrame, hdrInc, recInc, dropRec, ovfSet;
    logic                canHdr, canRec;

`ifdef FMPS_STREAM_TIMESTAMP_EN
    logic [31:0] tsCount, tsLatch;
`endif

    function automatic logic [EW-1:0] hdrWord(input logic [7:0] s,
                                              input logic [CW-1:0] n);
        return {1'b0, {INDEX_WIDTH{1'b0}}, 8'hFA, s, 16'(n)};
    endfunction

    function automatic logic [EW-1:0] trlWord(input logic trunc,
                                              input logic [CW-1:0] n);
        return {1'b1, {INDEX_WIDTH{1'b0}}, 8'hFE, 7'b0, trunc, 16'(n)};
    endfunction

    // Number of FMPS marked present in the frame bitmap
    always_comb begin
        popCount = '0;
        for (int i = 0; i < NBITS; i++)
            popCount = popCount + CW'(fmpsBitmapAll[i]);
    end

    assign free   = (FIFO_AW+1)'(DEPTH) - count;
    // Headers need room for themselves plus the closing trailer; records
    // must leave that room intact so an opened packet can always be closed.
    assign canHdr = free >= (FIFO_AW+1)'(RESERVE);
    assign canRec = free >  (FIFO_AW+1)'(RESERVE);

    // Write-side state register
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) state <= IDLE;
        else             state <= stateNext;
    end

    // Write-side next state and the single FIFO write of this cycle
    always_comb begin
        stateNext  = state;
        wrEn       = 1'b0;
        wrWord     = '0;
        latchFrame = 1'b0;
        hdrInc     = 1'b0;
        recInc     = 1'b0;
        dropRec    = 1'b0;
        ovfSet     = 1'b0;
        unique case (state)
            IDLE: begin
                dropRec = fmpsValid;
                if (FAstrobe) begin
                    if (canHdr) begin
                        wrEn       = 1'b1;
                        wrWord     = hdrWord(seq, popCount);
                        latchFrame = 1'b1;
                        hdrInc     = 1'b1;
`ifdef FMPS_STREAM_TIMESTAMP_EN
                        stateNext  = STAMP;
`else
                        stateNext  = COLLECT;
`endif
                    end else begin
                        ovfSet = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (received == expected) begin
                    wrEn      = 1'b1;
                    wrWord    = trlWord(1'b0, received);
                    dropRec   = fmpsValid;
                    stateNext = IDLE;
                    if (FAstrobe) begin
                        latchFrame = 1'b1;
                        stateNext  = OPEN;
                    end
                end else if (FAstrobe) begin
                    wrEn       = 1'b1;
                    wrWord     = trlWord(1'b1, received);
                    dropRec    = fmpsValid;
                    latchFrame = 1'b1;
                    stateNext  = OPEN;
                end else if (fmpsValid) begin
                    if (canRec) begin
                        wrEn   = 1'b1;
                        wrWord = {1'b0, fmpsIndex, fmpsData};
                        recInc = 1'b1;
                    end else begin
                        dropRec = 1'b1;
                        ovfSet  = 1'b1;
                    end
                end
            end
            OPEN: begin
                dropRec = fmpsValid;
                if (canHdr) begin
                    wrEn      = 1'b1;
                    wrWord    = hdrWord(seq, expected);
                    hdrInc    = 1'b1;
`ifdef FMPS_STREAM_TIMESTAMP_EN
                    stateNext = STAMP;
`else
                    stateNext = COLLECT;
`endif
                end else begin
                    // No room to open and close a packet: skip this frame.
                    ovfSet    = 1'b1;
                    stateNext = IDLE;
                end
            end
`ifdef FMPS_STREAM_TIMESTAMP_EN
            STAMP: begin
                dropRec   = fmpsValid;
                wrEn      = 1'b1;
                wrWord    = {1'b0, {INDEX_WIDTH{1'b0}}, tsLatch};
                stateNext = COLLECT;
            end
`endif
            default: stateNext = IDLE;
        endcase
    end

    // Packet bookkeeping: sequence, expected/received counts, drop stats
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            seq       <= '0;
            expected  <= '0;
            received  <= '0;
            dropCount <= '0;
            overflow  <= 1'b0;
        end else begin
            if (hdrInc) seq <= seq + 8'd1;
            if (latchFrame) begin
                expected <= popCount;
                received <= '0;
            end else if (recInc) begin
                received <= received + CW'(1);
            end
            if (dropRec && dropCount != 16'hFFFF)
                dropCount <= dropCount + 16'd1;
            if (ovfSet) overflow <= 1'b1;
        end
    end

`ifdef FMPS_STREAM_TIMESTAMP_EN
    // Free-running cycle counter, captured on each accepted frame marker
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            tsCount <= '0;
            tsLatch <= '0;
        end else begin
            tsCount <= tsCount + 32'd1;
            if (latchFrame) tsLatch <= tsCount;
        end
    end
`endif

    assign rdEn = M_TVALID & M_TREADY;

    // FIFO pointers and occupancy
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (wrEn) wrPtr <= wrPtr + FIFO_AW'(1);
            if (rdEn) rdPtr <= rdPtr + FIFO_AW'(1);
            count <= count + (FIFO_AW+1)'(wrEn) - (FIFO_AW+1)'(rdEn);
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge sysClk) begin
        if (wrEn) mem[wrPtr] <= wrWord;
    end

    assign headWord = mem[rdPtr];
    assign M_TVALID = count != '0;
    assign M_TDATA  = M_TVALID ? headWord[31:0] : '0;
    assign M_TUSER  = M_TVALID ? headWord[32 +: INDEX_WIDTH] : '0;
    assign M_TLAST  = M_TVALID ? headWord[EW-1] : 1'b0;

endmodule

// File: tb/tb_fmps_stream_packetizer.sv
// Directed vector bench for fmps_stream_packetizer (default parameters).
// Cycle-level table plus hand sequences for stall, overflow and reset.
module tb_fmps_stream_packetizer;

    logic        sysClk = 1'b0;
    logic        sysReset_n = 1'b1;
    logic        FAstrobe = 1'b0;
    logic [31:0] fmpsBitmapAll = '0;
    logic [4:0]  fmpsIndex = '0;
    logic [31:0] fmpsData = '0;
    logic        fmpsValid = 1'b0;
    logic [31:0] M_TDATA;
    logic [4:0]  M_TUSER;
    logic        M_TVALID;
    logic        M_TLAST;
    logic        M_TREADY = 1'b0;
    logic [15:0] dropCount;
    logic        overflow;

    fmps_stream_packetizer dut (
        .sysClk(sysClk), .sysReset_n(sysReset_n), .FAstrobe(FAstrobe),
        .fmpsBitmapAll(fmpsBitmapAll), .fmpsIndex(fmpsIndex),
        .fmpsData(fmpsData), .fmpsValid(fmpsValid),
        .M_TDATA(M_TDATA), .M_TUSER(M_TUSER), .M_TVALID(M_TVALID),
        .M_TLAST(M_TLAST), .M_TREADY(M_TREADY),
        .dropCount(dropCount), .overflow(overflow)
    );

    always #5 sysClk = ~sysClk;

    typedef struct {
        logic rst; logic stb; logic [31:0] bm;
        logic vld; logic [4:0] idx; logic [31:0] dat; logic rdy;
        logic eV; logic [31:0] eD; logic [4:0] eU; logic eL;
        logic [15:0] eDrop;
    } vec_t;

    vec_t tbl[$];
    logic [37:0] expQ[$];
    int nVec = 0;
    int nMis = 0;
    int nLast;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic stb, input logic [31:0] bm,
                         input logic vld, input logic [4:0] idx,
                         input logic [31:0] dat);
        FAstrobe = stb; fmpsBitmapAll = bm;
        fmpsValid = vld; fmpsIndex = idx; fmpsData = dat;
    endtask

    task automatic tick();
        @(posedge sysClk); #1;
    endtask

    task automatic doReset();
        drive(0, 0, 0, 0, 0);
        M_TREADY = 1'b0;
        sysReset_n = 1'b0;
        @(posedge sysClk); #1;
        sysReset_n = 1'b1;
    endtask

    function automatic logic [63:0] outs();
        return {9'b0, M_TVALID, M_TLAST, M_TUSER, M_TDATA, dropCount};
    endfunction

    function automatic logic [63:0] head();
        return {26'b0, M_TVALID, M_TLAST, M_TUSER, M_TDATA};
    endfunction

    initial begin
        // rst stb bm vld idx dat rdy | eV eD eU eL eDrop
        tbl.push_back('{1,1,32'hF,0,0,0,1, 1,32'hFA00_0004,0,0,0});
        tbl.push_back('{0,0,32'h0,1,0,32'h1111_0000,1, 1,32'h1111_0000,0,0,0});
        tbl.push_back('{0,0,32'h0,1,1,32'h1111_0001,1, 1,32'h1111_0001,1,0,0});
        tbl.push_back('{0,0,32'h0,1,2,32'h1111_0002,1, 1,32'h1111_0002,2,0,0});
        tbl.push_back('{0,0,32'h0,1,3,32'h1111_0003,1, 1,32'h1111_0003,3,0,0});
        tbl.push_back('{0,0,32'h0,0,0,0,1, 1,32'hFE00_0004,0,1,0});
        tbl.push_back('{0,0,32'h0,0,0,0,1, 0,32'h0,0,0,0});
        tbl.push_back('{1,1,32'h0,0,0,0,1, 1,32'hFA00_0000,0,0,0});
        tbl.push_back('{0,0,32'h0,1,7,32'hDEAD,1, 1,32'hFE00_0000,0,1,1});
        tbl.push_back('{0,0,32'h0,1,8,32'hBEEF,1, 0,32'h0,0,0,2});
        tbl.push_back('{1,1,32'hF,0,0,0,1, 1,32'hFA00_0004,0,0,0});
        tbl.push_back('{0,0,32'h0,1,0,32'hA0,1, 1,32'hA0,0,0,0});
        tbl.push_back('{0,0,32'h0,1,1,32'hA1,1, 1,32'hA1,1,0,0});
        tbl.push_back('{0,1,32'hF,1,2,32'hA2,1, 1,32'hFE01_0002,0,1,1});
        tbl.push_back('{0,0,32'h0,0,0,0,1, 1,32'hFA01_0004,0,0,1});
        tbl.push_back('{0,0,32'h0,1,0,32'hB0,1, 1,32'hB0,0,0,1});
        tbl.push_back('{0,0,32'h0,0,0,0,1, 0,32'h0,0,0,1});

        #2 sysReset_n = 1'b0;
        #1;
        chk("reset_outputs", outs(), 64'h0);
        chk("reset_overflow", {63'b0, overflow}, 64'h0);
        @(posedge sysClk); #1;
        sysReset_n = 1'b1;

`ifndef FMPS_STREAM_TIMESTAMP_EN
        for (int k = 0; k < tbl.size(); k++) begin
            if (tbl[k].rst) doReset();
            M_TREADY = tbl[k].rdy;
            drive(tbl[k].stb, tbl[k].bm, tbl[k].vld, tbl[k].idx,
                  tbl[k].dat);
            tick();
            chk($sformatf("vec%0d", k), outs(),
                {9'b0, tbl[k].eV, tbl[k].eL, tbl[k].eU, tbl[k].eD,
                 tbl[k].eDrop});
        end

        // Output must hold while the sink stalls
        doReset();
        drive(1, 32'hF, 0, 0, 0);
        tick();
        chk("stall_hdr", head(), {26'b0, 2'b10, 5'd0, 32'hFA00_0004});
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 5'(i), 32'h5500 + i);
            tick();
            chk($sformatf("stall_hold%0d", i), head(),
                {26'b0, 2'b10, 5'd0, 32'hFA00_0004});
        end
        drive(0, 0, 0, 0, 0);
        M_TREADY = 1'b1;
        tick();
        chk("stall_release", head(), {26'b0, 2'b10, 5'd0, 32'h5500});

        // Three full frames into a stalled FIFO
        doReset();
        for (int f = 0; f < 3; f++) begin
            drive(1, 32'hFFFF_FFFF, 0, 0, 0);
            tick();
            for (int i = 0; i < 32; i++) begin
                drive(0, 32'hFFFF_FFFF, 1, 5'(i), 32'hC000_0000 | (f << 8) | i);
                tick();
            end
            drive(0, 0, 0, 0, 0);
            tick();
        end
        chk("ovf_flag", {63'b0, overflow}, 64'h1);
        chk("ovf_drops", {48'b0, dropCount}, 64'd37);
        expQ.push_back({1'b0, 5'd0, 32'hFA00_0020});
        for (int i = 0; i < 32; i++)
            expQ.push_back({1'b0, 5'(i), 32'hC000_0000 | i});
        expQ.push_back({1'b1, 5'd0, 32'hFE00_0020});
        expQ.push_back({1'b0, 5'd0, 32'hFA01_0020});
        for (int i = 0; i < 27; i++)
            expQ.push_back({1'b0, 5'(i), 32'hC000_0100 | i});
        expQ.push_back({1'b1, 5'd0, 32'hFE01_001B});
        M_TREADY = 1'b1;
        nLast = 0;
        for (int k = 0; k < expQ.size(); k++) begin
            if (M_TVALID && M_TLAST) nLast++;
            chk($sformatf("drain%0d", k), head(),
                {26'b0, 1'b1, expQ[k]});
            tick();
        end
        chk("drain_empty", {63'b0, M_TVALID}, 64'h0);
        chk("drain_tlast_count", 64'(nLast), 64'd2);

        // Reset in the middle of a packet
        doReset();
        drive(1, 32'hF, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 32'h77);
        tick();
        chk("midrst_pre", {63'b0, M_TVALID}, 64'h1);
        sysReset_n = 1'b0;
        #1;
        chk("midrst_now", outs(), 64'h0);
        sysReset_n = 1'b1;
        drive(1, 32'h3, 0, 0, 0);
        M_TREADY = 1'b1;
        tick();
        chk("midrst_hdr", head(), {26'b0, 2'b10, 5'd0, 32'hFA00_0002});
`endif

        // Frame marker at the 100th cycle after reset
        doReset();
        M_TREADY = 1'b1;
        repeat (100) @(posedge sysClk);
        #1;
        drive(1, 32'hF, 0, 0, 0);
        tick();
        chk("ts_hdr", head(), {26'b0, 2'b10, 5'd0, 32'hFA00_0004});
`ifdef FMPS_STREAM_TIMESTAMP_EN
        drive(0, 0, 0, 0, 0);
        tick();
        chk("ts_word", head(), {26'b0, 2'b10, 5'd0, 32'd100});
`else
        drive(0, 0, 1, 5'd5, 32'h1234);
        tick();
        chk("ts_absent", head(), {26'b0, 2'b10, 5'd5, 32'h1234});
`endif
        drive(0, 0, 0, 0, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/fmps_stream_packetizer.md
FMPS_STREAM_PACKETIZER -- requirements
Module: fmps_stream_packetizer

Interface
REQ-001 Parameter INDEX_WIDTH, default 5: width of the FMPS index, up to 2^INDEX_WIDTH FMPS.
REQ-002 Parameter FIFO_AW, default 6: output FIFO address width, giving 2^FIFO_AW entries.
REQ-003 sysClk  in  1  sole clock; all logic is on its rising edge.
REQ-004 sysReset_n  in  1  reset, asynchronous and active-low.
REQ-005 FAstrobe  in  1  single-cycle fast-acquisition frame marker.
REQ-006 fmpsBitmapAll  in  2^INDEX_WIDTH  present-FMPS bitmap, sampled on FAstrobe.
REQ-007 fmpsIndex  in  INDEX_WIDTH  record index.
REQ-008 fmpsData  in  32  record data.
REQ-009 fmpsValid  in  1  record strobe, one record per cycle, no back-pressure.
REQ-010 M_TDATA  out  32  AXI4-Stream output data.
REQ-011 M_TUSER  out  INDEX_WIDTH  record index; zero on header and trailer words.
REQ-012 M_TVALID / M_TLAST  out  1 each; M_TREADY  in  1.
REQ-013 dropCount  out  16  saturating count of discarded records.
REQ-014 overflow  out  1  sticky flag; cleared only by reset.

Function
REQ-015 The write side SHALL use states IDLE, COLLECT and OPEN, and SHALL perform at most one FIFO write per cycle.
REQ-016 On FAstrobe in IDLE:
- latch expected = popcount(fmpsBitmapAll), width INDEX_WIDTH+1;
- zero the received count;
- write header {8'hFA, seq[7:0], 16'(expected)};
- increment 8-bit seq, wrapping 255->0;
- go to COLLECT.
REQ-017 In COLLECT, each fmpsValid SHALL write {fmpsData, fmpsIndex} and increment received.
REQ-018 When received reaches expected, the write side SHALL write trailer {8'hFE, 7'b0, trunc=0, 16'(received)} on the next cycle and go to IDLE.
- With expected=0, the trailer follows the header on the next cycle.
REQ-019 On FAstrobe in COLLECT:
- drop that cycle's record, if any;
- write trailer with trunc=1;
- go to OPEN.
REQ-020 OPEN SHALL write the new header, with the same actions as REQ-016, on the next cycle and go to COLLECT; fmpsValid in OPEN is dropped.
REQ-021 fmpsValid in IDLE, in OPEN, or while a completion trailer is pending SHALL be dropped and SHALL increment dropCount, saturating at 16'hFFFF.
REQ-022 A record write to a full FIFO SHALL be discarded, SHALL set overflow and SHALL increment dropCount.
- Header and trailer writes are guaranteed by reserving 2 entries: records are refused when free entries < 3.
REQ-023 Read side: a word transfers when M_TVALID && M_TREADY; M_TVALID is high whenever the FIFO is non-empty.
REQ-024 M_TDATA, M_TUSER and M_TLAST SHALL remain stable while M_TVALID && !M_TREADY.
REQ-025 M_TLAST SHALL be 1 on trailer words only.
REQ-026 Latency from the write cycle to M_TVALID on an empty FIFO SHALL be 1 cycle.
REQ-027 Simultaneous FIFO read and write when full or empty SHALL be handled without loss or duplication.

Reset
REQ-028 Asserting sysReset_n low SHALL immediately force:
- state to IDLE;
- FIFO to empty, M_TVALID=0, M_TLAST=0, M_TDATA=0, M_TUSER=0;
- seq=0, dropCount=0, overflow=0, expected=0, received=0.
REQ-029 Reset asserted mid-packet SHALL discard the partial packet; the first packet after reset starts with seq=0.

Configuration
REQ-030 With macro FMPS_STREAM_TIMESTAMP_EN defined, a free-running 32-bit sysClk cycle counter (reset 0, wrapping) SHALL be latched on FAstrobe.
- Its value SHALL be written as a second header word immediately after the header.
- OPEN becomes two cycles, and the reserve in REQ-022 becomes 3 entries.
REQ-031 Without FMPS_STREAM_TIMESTAMP_EN, no counter SHALL exist and packets SHALL be header, records, trailer only.

Verification
REQ-032 Bitmap 32'h0000_000F, FAstrobe, 4 records idx 0..3, M_TREADY=1 -> words 0xFA00_0004, 4 data words with TUSER 0..3, then 0xFE00_0004 with TLAST; dropCount=0.
REQ-033 Bitmap 0, FAstrobe -> 0xFA00_0000 then 0xFE00_0000 with TLAST on consecutive cycles.
REQ-034 Bitmap 4'hF, 2 records, then FAstrobe coincident with a third record -> trailer 0xFE01_0002, header 0xFA01_0004, dropCount=1.
REQ-035 M_TREADY=0, bitmap all-ones, 3 consecutive frames of 32 records -> overflow=1, dropCount>0, every packet still ends with a TLAST trailer; data intact once M_TREADY=1.
REQ-036 Assert sysReset_n low mid-packet with M_TVALID=1 -> M_TVALID=0 the same cycle; next header is 0xFA00_xxxx.
REQ-037 With FMPS_STREAM_TIMESTAMP_EN, FAstrobe at cycle 100 after reset -> second word equals 100; without the macro, header is followed directly by the first record.
